// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and types for the FIFO read side
package fifo_pkg;
  localparam int FIFO_DW   = 128;
  localparam int DEF_OUT_W = 32;

  typedef logic [FIFO_DW-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_rd_buf.sv
// rtl/fifo_rd_buf.sv - two-entry circular buffer holding prefetched FIFO entries
module fifo_rd_buf
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  fifo_word_t push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] occ,
  output fifo_word_t head
);
  fifo_word_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;

  // Storage is cleared on reset so the unpacked output reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        occ <= occ + 2'd1;
      end else if (pop && !push) begin
        occ <= occ - 2'd1;
      end
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fifo_rd_unpacker.sv
// rtl/fifo_rd_unpacker.sv - drains the wide FIFO and unpacks entries into narrow stream words
module fifo_rd_unpacker
  import fifo_pkg::*;
#(
  parameter int IN_W  = FIFO_DW,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             o_fifo_rden,
  input  logic [IN_W-1:0]  i_fifo_rddata,
  input  logic             i_fifo_empty,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_last,
  output logic [31:0]      o_beat_cnt,
  output logic             o_busy
);
  localparam int RATIO     = IN_W / OUT_W;
  localparam int SEL_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BUF_DEPTH = 2;

  logic             inflight;
  logic [SEL_W-1:0] sel;
  logic [1:0]       occ;
  logic [1:0]       fill;
  fifo_word_t       head;
  logic             xfer;
  logic             pop;
  logic             push;

  fifo_rd_buf u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (i_fifo_rddata),
    .pop       (pop),
    .flush     (i_flush),
    .occ       (occ),
    .head      (head)
  );

  // Counting the in-flight read keeps a late capture from overrunning the buffer.
  assign fill        = occ + {1'b0, inflight};
  assign o_fifo_rden = !i_fifo_empty && !i_flush && (fill < 2'(BUF_DEPTH));

  assign o_valid = (occ != 2'd0) && !i_flush;
  assign o_data  = head[int'(sel)*OUT_W +: OUT_W];
  assign o_last  = (sel == SEL_W'(RATIO-1));
  assign o_busy  = (occ != 2'd0) || inflight;

  assign xfer = o_valid && i_ready;
  assign pop  = xfer && o_last;
  assign push = inflight && !i_flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight   <= 1'b0;
      sel        <= '0;
      o_beat_cnt <= 32'd0;
    end else begin
      inflight <= o_fifo_rden;
      if (i_flush) begin
        sel <= '0;
      end else if (xfer) begin
        sel <= pop ? '0 : sel + 1'b1;
      end
      if (pop) begin
        o_beat_cnt <= o_beat_cnt + 32'd1;
      end
    end
  end
endmodule

// File: doc/fifo_rd_unpacker.md
Name: fifo_rd_unpacker

Overview:
- Sits directly downstream of the 128-bit FIFO; drains it through the FIFO read port (rden, rddata, empty).
- Unpacks each 128-bit entry into IN_W/OUT_W narrow words on a valid/ready stream toward the consumer.
- Prefetches up to 2 entries so the output can sustain one word per cycle while the FIFO has data.

Parameters:
- IN_W, 128, FIFO data width; must equal FIFO data width.
- OUT_W, 32, output word width; IN_W must be an integer multiple of OUT_W.
- RATIO, IN_W/OUT_W (derived localparam), words per FIFO entry.
- BUF_DEPTH, 2, internal entry buffer depth; fixed at 2.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rstn, input, 1, asynchronous active-low reset.
- o_fifo_rden, output, 1, read strobe to the FIFO (FIFO i_rden).
- i_fifo_rddata, input, IN_W, FIFO read data (FIFO o_rddata); valid the cycle after o_fifo_rden.
- i_fifo_empty, input, 1, FIFO empty flag (FIFO o_empty).
- i_flush, input, 1, synchronous flush of buffered and partially unpacked data.
- o_valid, output, 1, output word valid.
- i_ready, input, 1, consumer ready.
- o_data, output, OUT_W, output word.
- o_last, output, 1, high on the final word of a 128-bit entry.
- o_beat_cnt, output, 32, count of fully consumed entries; wraps modulo 2^32.
- o_busy, output, 1, high when the buffer is non-empty or a read is in flight.

Behaviour:
- Reset (rstn low, async): o_fifo_rden=0, o_valid=0, o_data=0, o_last=0, o_beat_cnt=0, o_busy=0. Buffer is emptied, sel=0, inflight=0.
- Reset mid-operation: in-flight read data is discarded. The FIFO is reset by the same rstn.
- FIFO read latency is fixed at 1 cycle: data issued with rden at cycle N is captured at posedge N+1.
- Read issue is combinational: o_fifo_rden = !i_fifo_empty && !i_flush && (occ + inflight < 2), where occ is entries held (0..2) and inflight is a 1-bit flag set the cycle rden is high.
- The block never reads while the FIFO is empty; an underflow read is a bench error.
- Capture: when inflight=1, i_fifo_rddata is written into the buffer tail.
- Unpack: o_data = head[sel*OUT_W +: OUT_W]. Lane 0 (LSBs) goes first. o_last = (sel==RATIO-1).
- o_valid = (occ != 0).
- Handshake: a transfer occurs when o_valid && i_ready. While o_valid && !i_ready, o_data and o_last hold stable.
- On transfer, sel increments. At sel==RATIO-1: sel wraps to 0, the head is popped, and o_beat_cnt increments.
- Pop and capture may occur in the same cycle; occ is then unchanged and ordering is preserved.
- Throughput: with i_ready held high and the FIFO non-empty, o_valid stays continuous after initial fill. First word appears 2 cycles after the first rden (rden at N, capture at N+1, o_valid at N+1 after the clock edge).
- Flush: on a cycle with i_flush=1, occ becomes 0 and sel becomes 0; no rden is issued.
  - Any read in flight during flush (inflight=1) is still absorbed but discarded.
  - o_beat_cnt is not incremented by a flush.
  - A transfer in the flush cycle is ignored: o_valid is forced low during flush.
- o_busy = (occ != 0) || inflight.

Decomposition:
- Shared package fifo_pkg holds FIFO_DW=128, OUT_W default, and typedef fifo_word_t (logic [FIFO_DW-1:0]).
- Sub-module fifo_rd_buf: a 2-entry circular buffer with push, pop, flush, occ, and head outputs.
- The top-level block holds the read-issue logic, the inflight flag, the sel counter, and the beat counter.

Test Plan:
- FIFO holding one entry 0x44444444_33333333_22222222_11111111, i_ready=1 -> o_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, o_last on the 4th word only, o_beat_cnt=1, then o_valid=0.
- 8 entries preloaded, i_ready=1 -> 32 words with no o_valid gaps after the first; exactly 8 rden pulses, never with empty=1; o_beat_cnt=8.
- i_ready held 0 for 10 cycles mid-entry -> o_data and o_last stable; at most 2 rden issued in total; no rden while occ+inflight=2.
- i_flush asserted one cycle after an rden (inflight=1) with 1 entry buffered -> o_valid low next cycle; in-flight data discarded; o_beat_cnt unchanged; the next FIFO entry unpacks from lane 0.
- rstn pulsed low mid-entry at sel=2 -> all outputs 0 asynchronously; after release, rden resumes only when i_fifo_empty=0.
- Random i_ready (50%) with 100 random entries -> output stream equals the scoreboard unpack of the FIFO contents, and o_beat_cnt=100.
